// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code set 2 decoder: prefix FSM, modifier tracking and an event FIFO.
// Define PS2_PAUSE_KEY_EN to compile in the E1 (Pause key) sequence handling.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sync_reset,
  input  logic       enable_in,
  input  logic [7:0] data_in,
  output logic       event_valid,
  input  logic       event_ready,
  output logic [9:0] event_data,
  output logic [5:0] mod_flags,
  output logic       bat_pulse,
  output logic       err_pulse,
  output logic       overflow_pulse
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0]   FULL_CNT = (FIFO_DEPTH_LOG2+1)'(DEPTH);
  localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE  = (FIFO_DEPTH_LOG2+1)'(1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = (FIFO_DEPTH_LOG2)'(1);

`ifdef PS2_PAUSE_KEY_EN
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXT     = 3'd1,
    S_BRK     = 3'd2,
    S_EXT_BRK = 3'd3,
    S_PAUSE   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;
`endif

  state_t                     r_state;
  state_t                     w_state_nxt;
`ifdef PS2_PAUSE_KEY_EN
  logic [2:0]                 r_pcnt;
  logic [2:0]                 w_pcnt_nxt;
`endif
  logic                       w_push;
  logic [9:0]                 w_push_data;
  logic                       w_bat;
  logic                       w_err;
  logic [5:0]                 r_mod;
  logic                       r_bat;
  logic                       r_err;
  logic                       r_ovf;

  logic [9:0]                 r_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   r_count;
  logic                       r_valid;
  logic [9:0]                 r_head;
  logic                       w_pop;
  logic                       w_full;
  logic                       w_wr;
  logic                       w_ovf;
  logic [FIFO_DEPTH_LOG2-1:0] w_rd_nxt;
  logic [FIFO_DEPTH_LOG2:0]   w_cnt_nxt;
  logic [9:0]                 w_head_nxt;

  // Make sets and break clears the matching modifier; ev = {ext, brk, code}.
  function automatic logic [5:0] mod_update(input logic [5:0] m, input logic [9:0] ev);
    logic [5:0] r;
    r = m;
    case ({ev[9], ev[7:0]})
      9'h012:  r[0] = ~ev[8];
      9'h059:  r[1] = ~ev[8];
      9'h014:  r[2] = ~ev[8];
      9'h114:  r[3] = ~ev[8];
      9'h011:  r[4] = ~ev[8];
      9'h111:  r[5] = ~ev[8];
      default: r = m;
    endcase
    return r;
  endfunction

  // Prefix decode: next state, push request and status pulses for the current byte.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_push_data = 10'd0;
    w_bat       = 1'b0;
    w_err       = 1'b0;
`ifdef PS2_PAUSE_KEY_EN
    w_pcnt_nxt  = r_pcnt;
`endif
    if (enable_in) begin
      case (r_state)
        S_IDLE: begin
          case (data_in)
            8'hE0: w_state_nxt = S_EXT;
            8'hF0: w_state_nxt = S_BRK;
            8'hE1: begin
`ifdef PS2_PAUSE_KEY_EN
              w_state_nxt = S_PAUSE;
              w_pcnt_nxt  = 3'd0;
`else
              w_state_nxt = S_IDLE;
`endif
            end
            8'hAA:               w_bat = 1'b1;
            8'h00, 8'hFF, 8'hFC: w_err = 1'b1;
            8'hFA, 8'hFE:        w_push = 1'b0;
            default: begin
              w_push      = 1'b1;
              w_push_data = {2'b00, data_in};
            end
          endcase
        end
        S_EXT: begin
          case (data_in)
            8'hF0: w_state_nxt = S_EXT_BRK;
            8'hE0: w_state_nxt = S_EXT;
            default: begin
              w_push      = 1'b1;
              w_push_data = {2'b10, data_in};
              w_state_nxt = S_IDLE;
            end
          endcase
        end
        S_BRK, S_EXT_BRK: begin
          w_state_nxt = S_IDLE;
          case (data_in)
            8'hE0, 8'hF0, 8'hE1: w_err = 1'b1;
            default: begin
              w_push      = 1'b1;
              w_push_data = {(r_state == S_EXT_BRK), 1'b1, data_in};
            end
          endcase
        end
`ifdef PS2_PAUSE_KEY_EN
        S_PAUSE: begin
          if (r_pcnt == 3'd6) begin
            w_push      = 1'b1;
            w_push_data = 10'h2E1;
            w_pcnt_nxt  = 3'd0;
            w_state_nxt = S_IDLE;
          end else begin
            w_pcnt_nxt  = r_pcnt + 3'd1;
          end
        end
`endif
        default: w_state_nxt = S_IDLE;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  assign w_pop    = event_ready && (r_count != '0);
  assign w_full   = (r_count == FULL_CNT);
  assign w_wr     = w_push && (!w_full || w_pop);
  assign w_ovf    = w_push && w_full && !w_pop;
  assign w_rd_nxt = w_pop ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;

  // FIFO occupancy and the next head entry; a lone fresh push bypasses the array.
  always_comb begin
    case ({w_wr, w_pop})
      2'b10:   w_cnt_nxt = r_count + CNT_ONE;
      2'b01:   w_cnt_nxt = r_count - CNT_ONE;
      default: w_cnt_nxt = r_count;
    endcase
    if (w_cnt_nxt == '0) begin
      w_head_nxt = 10'd0;
    end else if (w_wr && (w_cnt_nxt == CNT_ONE)) begin
      w_head_nxt = w_push_data;
    end else begin
      w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  // Decoder state, modifiers, pulses and FIFO control.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
`ifdef PS2_PAUSE_KEY_EN
      r_pcnt   <= 3'd0;
`endif
      r_mod    <= 6'd0;
      r_bat    <= 1'b0;
      r_err    <= 1'b0;
      r_ovf    <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_head   <= 10'd0;
    end else if (sync_reset) begin
      r_state  <= S_IDLE;
`ifdef PS2_PAUSE_KEY_EN
      r_pcnt   <= 3'd0;
`endif
      r_mod    <= 6'd0;
      r_bat    <= 1'b0;
      r_err    <= 1'b0;
      r_ovf    <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_head   <= 10'd0;
    end else begin
      r_state  <= w_state_nxt;
`ifdef PS2_PAUSE_KEY_EN
      r_pcnt   <= w_pcnt_nxt;
`endif
      r_mod    <= w_push ? mod_update(r_mod, w_push_data) : r_mod;
      r_bat    <= w_bat;
      r_err    <= w_err;
      r_ovf    <= w_ovf;
      r_wr_ptr <= w_wr ? (r_wr_ptr + PTR_ONE) : r_wr_ptr;
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_cnt_nxt;
      r_valid  <= (w_cnt_nxt != '0);
      r_head   <= w_head_nxt;
    end
  end

  // Event storage array.
  always_ff @(posedge clk) begin
    if (w_wr && !sync_reset && !reset) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  assign event_valid    = r_valid;
  assign event_data     = r_head;
  assign mod_flags      = r_mod;
  assign bat_pulse      = r_bat;
  assign err_pulse      = r_err;
  assign overflow_pulse = r_ovf;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed self-checking bench for ps2_scancode_decoder (default FIFO depth 8).
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sync_reset = 1'b0;
  logic       enable_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       event_valid;
  logic       event_ready = 1'b0;
  logic [9:0] event_data;
  logic [5:0] mod_flags;
  logic       bat_pulse;
  logic       err_pulse;
  logic       overflow_pulse;

  int checks = 0;
  int errors = 0;

  ps2_scancode_decoder #(.FIFO_DEPTH_LOG2(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .sync_reset     (sync_reset),
    .enable_in      (enable_in),
    .data_in        (data_in),
    .event_valid    (event_valid),
    .event_ready    (event_ready),
    .event_data     (event_data),
    .mod_flags      (mod_flags),
    .bat_pulse      (bat_pulse),
    .err_pulse      (err_pulse),
    .overflow_pulse (overflow_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one byte for exactly one cycle; returns at the negedge after the capturing edge.
  task automatic send(input logic [7:0] b);
    enable_in = 1'b1;
    data_in   = b;
    @(negedge clk);
    enable_in = 1'b0;
    data_in   = 8'h00;
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_valid", 16'(event_valid), 16'h0);
    chk("rst_data", 16'(event_data), 16'h000);
    chk("rst_mod", 16'(mod_flags), 16'h00);
    chk("rst_pulses", 16'({bat_pulse, err_pulse, overflow_pulse}), 16'h0);

    // Basic make / break / extended break, consumer always ready.
    event_ready = 1'b1;
    send(8'h1C);
    chk("make_valid", 16'(event_valid), 16'h1);
    chk("make_data", 16'(event_data), 16'h01C);
    send(8'hF0);
    chk("prefix_no_event", 16'(event_valid), 16'h0);
    send(8'h1C);
    chk("break_data", 16'(event_data), 16'h11C);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("ext_break_data", 16'(event_data), 16'h375);

    // Modifiers: bit order {ralt, lalt, rctrl, lctrl, rshift, lshift}.
    send(8'hE0); send(8'h14);
    chk("rctrl_data", 16'(event_data), 16'h214);
    chk("rctrl_mod", 16'(mod_flags), 16'h08);
    send(8'h12);
    chk("lshift_mod", 16'(mod_flags), 16'h09);
    send(8'hE0); send(8'hF0); send(8'h14);
    chk("rctrl_brk_data", 16'(event_data), 16'h314);
    chk("rctrl_brk_mod", 16'(mod_flags), 16'h01);
    send(8'hF0); send(8'h12);
    chk("lshift_brk_mod", 16'(mod_flags), 16'h00);

    // Status bytes and illegal prefix order.
    send(8'hAA);
    chk("bat_pulse", 16'(bat_pulse), 16'h1);
    chk("bat_no_event", 16'(event_valid), 16'h0);
    idle();
    chk("bat_one_cycle", 16'(bat_pulse), 16'h0);
    send(8'hFF);
    chk("err_ff", 16'(err_pulse), 16'h1);
    send(8'hF0); send(8'hE0);
    chk("err_prefix", 16'(err_pulse), 16'h1);
    send(8'h1C);
    chk("after_err_data", 16'(event_data), 16'h01C);
    chk("after_err_pulse", 16'(err_pulse), 16'h0);
    idle();
    chk("drained", 16'(event_valid), 16'h0);

    // Fill the FIFO; the ninth push is dropped.
    event_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      send(8'(i));
      chk($sformatf("ovf_%0d", i), 16'(overflow_pulse), (i == 9) ? 16'h1 : 16'h0);
    end
    chk("full_head", 16'(event_data), 16'h001);
    idle();
    chk("ovf_one_cycle", 16'(overflow_pulse), 16'h0);

    // Push with a simultaneous pop while full is accepted, then drain in order.
    event_ready = 1'b1;
    send(8'h0A);
    chk("full_pushpop_ovf", 16'(overflow_pulse), 16'h0);
    chk("full_pushpop_head", 16'(event_data), 16'h002);
    for (int j = 3; j <= 8; j++) begin
      idle();
      chk($sformatf("drain_%0d", j), 16'(event_data), 16'(j));
    end
    idle();
    chk("drain_last", 16'(event_data), 16'h00A);
    chk("drain_last_valid", 16'(event_valid), 16'h1);
    idle();
    chk("drain_empty", 16'(event_valid), 16'h0);
    chk("drain_empty_data", 16'(event_data), 16'h000);

    // Pause sequence E1 14 77 E1 F0 14 F0 77.
`ifdef PS2_PAUSE_KEY_EN
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0);
    chk("pause_swallow", 16'(event_valid), 16'h0);
    chk("pause_mod_mid", 16'(mod_flags), 16'h00);
    send(8'h77);
    chk("pause_data", 16'(event_data), 16'h2E1);
    chk("pause_mod", 16'(mod_flags), 16'h00);
    idle();
    chk("pause_single", 16'(event_valid), 16'h0);
`else
    send(8'hE1);
    chk("e1_ignored", 16'(event_valid), 16'h0);
    send(8'h14);
    chk("e1_seq_014", 16'(event_data), 16'h014);
    chk("e1_seq_lctrl_on", 16'(mod_flags), 16'h04);
    send(8'h77);
    chk("e1_seq_077", 16'(event_data), 16'h077);
    send(8'hE1);
    chk("e1_ignored2", 16'(event_valid), 16'h0);
    send(8'hF0); send(8'h14);
    chk("e1_seq_114", 16'(event_data), 16'h114);
    chk("e1_seq_lctrl_off", 16'(mod_flags), 16'h00);
    send(8'hF0); send(8'h77);
    chk("e1_seq_177", 16'(event_data), 16'h177);
    idle();
`endif

    // Synchronous flush discards the queue, pending prefix and the concurrent byte.
    event_ready = 1'b0;
    send(8'h1C);
    send(8'hE0);
    sync_reset = 1'b1;
    send(8'h33);
    sync_reset = 1'b0;
    chk("srst_valid", 16'(event_valid), 16'h0);
    chk("srst_data", 16'(event_data), 16'h000);
    send(8'h1C);
    chk("srst_prefix_cleared", 16'(event_data), 16'h01C);

    // Asynchronous reset between E0 and its code byte.
    event_ready = 1'b1;
    send(8'hE0);
    #1 reset = 1'b1;
    #1;
    chk("arst_valid", 16'(event_valid), 16'h0);
    @(negedge clk);
    reset = 1'b0;
    send(8'h1C);
    chk("arst_prefix_cleared", 16'(event_data), 16'h01C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
